aes_inv_round_iterative: RTL and testbench

//  AES-256 inverse cipher engine: decrypts one 128-bit block per request by iterating one inverse round per clock.

---
 rtl/aes_inv_round_iterative.sv | 178 +++++++++++++++++
 tb/tb_aes_inv_round_iterative.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_iterative.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_inv_round_iterative: AES-256 inverse cipher, one inverse round per clock
// Revision: 1.0
// ----------------------------------------------------------------------------
module aes_inv_round_iterative #(
  parameter int NB_BYTE  = 8,
  parameter int N_BYTES  = 16,
  parameter int N_ROUNDS = 14
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [N_BYTES*NB_BYTE-1:0]             i_state,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [N_BYTES*NB_BYTE*(N_ROUNDS+1)-1:0] i_round_key_vector,
  input  logic                                   i_abort,
  output logic [N_BYTES*NB_BYTE-1:0]             o_state,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic                                   o_busy
);

  localparam int c_w     = N_BYTES * NB_BYTE;
  localparam int c_cnt_w = $clog2(N_ROUNDS);

  if (NB_BYTE != 8 || N_BYTES != 16 || N_ROUNDS != 14) begin : g_bad_conf
    $error("BAD_CONF: only NB_BYTE=8, N_BYTES=16, N_ROUNDS=14 supported");
  end

  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               fsm_q, fsm_d;
  logic [c_w-1:0]       state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  logic [c_w-1:0]       w_last_key;
  logic [c_w-1:0]       w_round_key;
  logic [c_w-1:0]       w_isr;
  logic [c_w-1:0]       w_isb;
  logic [c_w-1:0]       w_ark;
  logic [c_w-1:0]       w_imc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // k selects which of b, 2b, 4b, 8b are summed; covers 09, 0b, 0d, 0e
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Byte k of the state is row k%4, column k/4, at bits [127-8k -: 8]
  function automatic logic [c_w-1:0] inv_shift_rows(input logic [c_w-1:0] s);
    logic [c_w-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[c_w-1-8*(4*c+w) -: 8] = s[c_w-1-8*(4*((c-w+4)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [c_w-1:0] inv_sub_bytes(input logic [c_w-1:0] s);
    logic [c_w-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[c_w-1-8*k -: 8] = c_inv_sbox[(255 - int'(s[c_w-1-8*k -: 8]))*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [c_w-1:0] inv_mix_columns(input logic [c_w-1:0] s);
    logic [c_w-1:0] r;
    logic [7:0]     a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c_w-1-32*c -: 8];
      a1 = s[c_w-9-32*c -: 8];
      a2 = s[c_w-17-32*c -: 8];
      a3 = s[c_w-25-32*c -: 8];
      r[c_w-1-32*c -: 8]  = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      r[c_w-9-32*c -: 8]  = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      r[c_w-17-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      r[c_w-25-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return r;
  endfunction

  assign w_last_key  = i_round_key_vector[N_ROUNDS*c_w +: c_w];
  assign w_round_key = i_round_key_vector[int'(cnt_q)*c_w +: c_w];
  assign w_isr       = inv_shift_rows(state_q);
  assign w_isb       = inv_sub_bytes(w_isr);
  assign w_ark       = w_isb ^ w_round_key;
  assign w_imc       = inv_mix_columns(w_ark);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_abort) begin
      fsm_d   = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (i_valid) begin
            state_d = i_state ^ w_last_key;
            cnt_d   = c_cnt_w'(N_ROUNDS - 1);
            fsm_d   = ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (cnt_q != '0) begin
            state_d = w_imc;
            cnt_d   = cnt_q - c_cnt_w'(1);
          end else begin
            state_d = w_ark;
            fsm_d   = ST_DONE;
            valid_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_d = 1'b0;
            fsm_d   = ST_IDLE;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_state = state_q;
  assign o_valid = valid_q;
  assign o_ready = (fsm_q == ST_IDLE);
  assign o_busy  = (fsm_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_round_iterative.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_inv_round_iterative: directed and randomized bench for the AES-256 decrypt engine
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_aes_inv_round_iterative;

  logic           clk;
  logic           rst_n;
  logic [127:0]   i_state;
  logic           i_valid;
  logic           o_ready;
  logic [1919:0]  rkv;
  logic           i_abort;
  logic [127:0]   o_state;
  logic           o_valid;
  logic           i_ready;
  logic           o_busy;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] c_c3_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] c_c3_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] c_c3_pt  = 128'h00112233445566778899aabbccddeeff;

  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_inv_round_iterative #(
    .NB_BYTE (8),
    .N_BYTES (16),
    .N_ROUNDS(14)
  ) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_state           (i_state),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_round_key_vector(rkv),
    .i_abort           (i_abort),
    .o_state           (o_state),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_busy            (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- software AES-256 encrypt model ----------------
  function automatic logic [7:0] sb(input logic [7:0] b);
    return c_sbox[(255 - int'(b))*8 +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] v;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    v = '0;
    for (int r = 0; r < 15; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1919:0] v);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ v[127-8*i -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sb(s[4*((c+r)%4)+r]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 14) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ v[rnd*128 + 127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_block(input logic [127:0] ct);
    i_state = ct;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_state = ~ct;
  endtask

  // n = edges counted since the accept edge until o_valid, -1 on timeout
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!o_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) n = -1;
  endtask

  task automatic handoff();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_state = '0; i_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b0; rkv = '0;
    #12;
    checks++; if (o_state !== 128'h0) begin errors++; $display("FAIL reset o_state: got %h expected 0", o_state); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset o_busy: got %b expected 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset o_ready: got %b expected 1", o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int n;
    rkv = expand_key(c_c3_key);
    send_block(c_c3_ct);
    checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      errors++; $display("FAIL fips busy/ready after accept: got busy=%b ready=%b expected 1/0", o_busy, o_ready); end
    wait_valid(40, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL fips latency: got %0d expected 14", n); end
    checks++; if (o_state !== c_c3_pt) begin errors++; $display("FAIL fips plaintext: got %h expected %h", o_state, c_c3_pt); end
    handoff();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL fips handoff: got valid=%b ready=%b expected 0/1", o_valid, o_ready); end
  endtask

  task automatic test_backpressure();
    int n;
    send_block(c_c3_ct);
    wait_valid(40, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL bp latency: got %0d expected 14", n); end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_state !== c_c3_pt || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold cycle %0d: got valid=%b ready=%b state=%h expected 1/0/%h", k, o_valid, o_ready, o_state, c_c3_pt);
      end
      i_valid = k[0];
      i_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    i_valid = 1'b0;
    handoff();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL bp release: got valid=%b ready=%b expected 0/1", o_valid, o_ready); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp ignored pulses: got busy=%b expected 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    int sent, got, cyc, last;
    pt[0] = c_c3_pt;
    pt[1] = 128'h0123456789abcdeffedcba9876543210;
    pt[2] = 128'hdeadbeefcafebabe0badf00d12345678;
    for (int i = 0; i < 3; i++) ct[i] = aes_enc(pt[i], rkv);
    sent = 0; got = 0; cyc = 0; last = 0;
    i_ready = 1'b1;
    while (got < 3 && cyc < 120) begin
      if (o_valid) begin
        checks++; if (o_state !== pt[got]) begin
          errors++; $display("FAIL b2b result %0d: got %h expected %h", got, o_state, pt[got]); end
        if (got > 0) begin
          checks++; if (cyc - last !== 16) begin
            errors++; $display("FAIL b2b spacing %0d: got %0d expected 16", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (o_ready) begin
        if (sent < 3) begin
          i_state = ct[sent];
          i_valid = 1'b1;
          sent++;
        end else begin
          i_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++; if (got !== 3) begin errors++; $display("FAIL b2b count: got %0d results expected 3", got); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    logic [127:0] pt;
    send_block(c_c3_ct);
    repeat (6) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL abort round: got busy=%b ready=%b valid=%b expected 0/1/0", o_busy, o_ready, o_valid); end
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (o_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort no_valid: got o_valid pulse, expected none"); end
    i_state = c_c3_ct; i_valid = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_abort = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL abort idle blocks accept: got busy=%b ready=%b expected 0/1", o_busy, o_ready); end
    pt = 128'h0123456789abcdeffedcba9876543210;
    send_block(aes_enc(pt, rkv));
    wait_valid(40, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL abort next latency: got %0d expected 14", n); end
    checks++; if (o_state !== pt) begin errors++; $display("FAIL abort next plaintext: got %h expected %h", o_state, pt); end
    handoff();
  endtask

  task automatic test_async_reset();
    int n;
    bit seen;
    send_block(c_c3_ct);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_state !== 128'h0) begin
      errors++; $display("FAIL async reset: got busy=%b ready=%b valid=%b state=%h expected 0/1/0/0", o_busy, o_ready, o_valid, o_state); end
    @(negedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (o_valid || o_busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL async reset discard: got valid/busy activity, expected none"); end
    send_block(c_c3_ct);
    wait_valid(40, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL async reset resubmit latency: got %0d expected 14", n); end
    checks++; if (o_state !== c_c3_pt) begin errors++; $display("FAIL async reset resubmit: got %h expected %h", o_state, c_c3_pt); end
    handoff();
  endtask

  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt;
    int n;
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      rkv = expand_key(key);
      send_block(aes_enc(pt, rkv));
      wait_valid(40, n);
      checks++; if (n !== 14) begin errors++; $display("FAIL random %0d latency: got %0d expected 14", b, n); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (o_valid !== 1'b1 || o_state !== pt) begin
        errors++; $display("FAIL random %0d plaintext: got valid=%b state=%h expected 1/%h", b, o_valid, o_state, pt); end
      handoff();
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
